// File: rtl/card_pkg.sv
// Shared constants, FSM state type and the rank-to-points mapping for the card dealer.
package card_pkg;

  localparam logic [3:0] ACE = 4'd1;
  localparam logic [3:0] KING = 4'd13;
  localparam int unsigned NUM_RANKS = 13;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StProbe,
    StDeal
  } state_e;

  // Aces count as 1 here; soft-ace promotion is the scorer's job.
  function automatic logic [3:0] rank_points(input logic [3:0] rank);
    if (rank >= 4'd10) begin
      return 4'd10;
    end
    return rank;
  endfunction

endpackage

// File: rtl/rank_tracker.sv
// Per-rank dealt counters for one deck, plus the remaining-card count and its empty flag.
module rank_tracker
  import card_pkg::*;
#(
  parameter int unsigned COPIES = 4,
  localparam int unsigned CW = $clog2(COPIES + 1),
  localparam int unsigned LW = $clog2(NUM_RANKS * COPIES + 1)
) (
  input  logic          clk_50M,
  input  logic          i_Reset_n,
  input  logic          i_Clear,
  input  logic          i_Inc,
  input  logic [3:0]    i_IncIdx,
  input  logic [3:0]    i_ProbeIdx,
  output logic          o_Full,
  output logic [LW-1:0] o_CardsLeft,
  output logic          o_DeckEmpty
);

  localparam logic [LW-1:0] DECK = LW'(NUM_RANKS * COPIES);
  localparam logic [CW-1:0] COPIES_W = CW'(COPIES);

  logic [CW-1:0] dealt_q [NUM_RANKS];
  logic [LW-1:0] left_q;
  logic          empty_q;

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < NUM_RANKS; i++) begin
        dealt_q[i] <= '0;
      end
      left_q  <= DECK;
      empty_q <= 1'b0;
    end else if (i_Clear) begin
      for (int i = 0; i < NUM_RANKS; i++) begin
        dealt_q[i] <= '0;
      end
      left_q  <= DECK;
      empty_q <= 1'b0;
    end else if (i_Inc) begin
      dealt_q[i_IncIdx] <= dealt_q[i_IncIdx] + CW'(1);
      left_q            <= left_q - LW'(1);
      // Registered compare so the flag moves in the same cycle as the count.
      empty_q           <= (left_q == LW'(1));
    end
  end

  always_comb begin
    o_Full = 1'b0;
    if (i_ProbeIdx < 4'(NUM_RANKS)) begin
      o_Full = (dealt_q[i_ProbeIdx] >= COPIES_W);
    end
  end

  assign o_CardsLeft = left_q;
  assign o_DeckEmpty = empty_q;

endmodule

// File: rtl/card_dealer.sv
// Deals one card per request from a single tracked deck, using the low bits of the
// free-running count as entropy and probing forward past exhausted ranks.
module card_dealer
  import card_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned COPIES = 4,
  localparam int unsigned LW = $clog2(NUM_RANKS * COPIES + 1)
) (
  input  logic             clk_50M,
  input  logic             i_Reset_n,
  input  logic [WIDTH-1:0] i_Count,
  input  logic             i_DrawReq,
  input  logic             i_Shuffle,
  output logic [3:0]       o_Card,
  output logic [3:0]       o_Points,
  output logic             o_CardValid,
  output logic             o_Busy,
  output logic [LW-1:0]    o_CardsLeft,
  output logic             o_DeckEmpty,
  output logic             o_DrawErr
);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] card_q, card_d;
  logic [3:0] points_q, points_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       inc, clear, full;
  logic [3:0] n;

  logic unused_count;
  assign unused_count = ^i_Count[WIDTH-1:4];
  assign n = i_Count[3:0];

  rank_tracker #(
    .COPIES(COPIES)
  ) u_rank_tracker (
    .clk_50M    (clk_50M),
    .i_Reset_n  (i_Reset_n),
    .i_Clear    (clear),
    .i_Inc      (inc),
    .i_IncIdx   (idx_q),
    .i_ProbeIdx (idx_q),
    .o_Full     (full),
    .o_CardsLeft(o_CardsLeft),
    .o_DeckEmpty(o_DeckEmpty)
  );

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      card_q   <= '0;
      points_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      card_q   <= card_d;
      points_q <= points_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    card_d   = card_q;
    points_d = points_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    inc      = 1'b0;
    clear    = 1'b0;
    if (i_Shuffle) begin
      // Drops any draw in flight; the last dealt card stays visible.
      state_d = StIdle;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_DrawReq) begin
            if (o_DeckEmpty) begin
              err_d = 1'b1;
            end else begin
              state_d = StSample;
            end
          end
        end
        StSample: begin
          idx_d   = (n >= 4'd13) ? n - 4'd13 : n;
          state_d = StProbe;
        end
        StProbe: begin
          // Deck is known non-empty, so this walk always finds a free rank.
          if (!full) begin
            state_d = StDeal;
          end else begin
            idx_d = (idx_q == KING - 4'd1) ? 4'd0 : idx_q + 4'd1;
          end
        end
        StDeal: begin
          inc      = 1'b1;
          card_d   = idx_q + ACE;
          points_d = rank_points(idx_q + ACE);
          valid_d  = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign o_Card      = card_q;
  assign o_Points    = points_q;
  assign o_CardValid = valid_q;
  assign o_Busy      = (state_q != StIdle);
  assign o_DrawErr   = err_q;

endmodule
